// File: rtl/cpu_exec_unit.sv
// Handshaked execution unit: single-cycle ALU ops plus iterative shift-add multiply.
// Define EXEC_DIV_EN to build the restoring divider for DIV/MOD; otherwise those opcodes are illegal.
module cpu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int OPW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB = OPW'(1);
    localparam logic [OPW-1:0] OP_AND = OPW'(2);
    localparam logic [OPW-1:0] OP_OR  = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR = OPW'(4);
    localparam logic [OPW-1:0] OP_SHL = OPW'(5);
    localparam logic [OPW-1:0] OP_SHR = OPW'(6);
    localparam logic [OPW-1:0] OP_MUL = OPW'(7);
`ifdef EXEC_DIV_EN
    localparam logic [OPW-1:0] OP_DIV = OPW'(8);
    localparam logic [OPW-1:0] OP_MOD = OPW'(9);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_ITER,
        S_DONE
    } state_t;

    state_t           state_reg;
    logic [OPW-1:0]   op_reg;
    logic [WIDTH-1:0] opa_reg;
    logic [WIDTH-1:0] opb_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [CW-1:0]    cnt_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic             carry_reg;
    logic             err_reg;

    logic             start_iter;
    logic [WIDTH:0]   sum_wide;
    logic [WIDTH:0]   diff_wide;
    logic [WIDTH-1:0] exec_result_next;
    logic             exec_carry_next;
    logic             exec_err_next;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] opa_next;
    logic [WIDTH-1:0] opb_next;
    logic [WIDTH-1:0] iter_result;
`ifdef EXEC_DIV_EN
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
`endif

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;
    assign zero   = zero_reg;
    assign carry  = carry_reg;
    assign err    = err_reg;

    // Divide-by-zero never iterates; it is resolved in the single-cycle path.
    always_comb begin
        start_iter = (opcode == OP_MUL);
`ifdef EXEC_DIV_EN
        if ((opcode == OP_DIV || opcode == OP_MOD) && b != '0) begin
            start_iter = 1'b1;
        end
`endif
    end

    always_comb begin
        sum_wide         = {1'b0, opa_reg} + {1'b0, opb_reg};
        diff_wide        = {1'b0, opa_reg} - {1'b0, opb_reg};
        exec_result_next = '0;
        exec_carry_next  = 1'b0;
        exec_err_next    = 1'b0;
        case (op_reg)
            OP_ADD: begin
                exec_result_next = sum_wide[WIDTH-1:0];
                exec_carry_next  = sum_wide[WIDTH];
            end
            OP_SUB: begin
                exec_result_next = diff_wide[WIDTH-1:0];
                exec_carry_next  = diff_wide[WIDTH];
            end
            OP_AND: exec_result_next = opa_reg & opb_reg;
            OP_OR:  exec_result_next = opa_reg | opb_reg;
            OP_XOR: exec_result_next = opa_reg ^ opb_reg;
            OP_SHL: exec_result_next = opa_reg << opb_reg[SHW-1:0];
            OP_SHR: exec_result_next = opa_reg >> opb_reg[SHW-1:0];
`ifdef EXEC_DIV_EN
            OP_DIV: begin
                exec_result_next = '1;
                exec_err_next    = 1'b1;
            end
            OP_MOD: begin
                exec_result_next = opa_reg;
                exec_err_next    = 1'b1;
            end
`endif
            default: exec_err_next = 1'b1;
        endcase
    end

    // One iteration step: acc/opa/opb hold product/multiplicand/multiplier,
    // or remainder/quotient-shifting-dividend/divisor.
    always_comb begin
        acc_next    = opb_reg[0] ? (acc_reg + opa_reg) : acc_reg;
        opa_next    = opa_reg << 1;
        opb_next    = opb_reg >> 1;
        iter_result = acc_reg;
`ifdef EXEC_DIV_EN
        div_shift = {acc_reg, opa_reg[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opb_reg});
        div_diff  = div_shift[WIDTH-1:0] - opb_reg;
        if (op_reg != OP_MUL) begin
            acc_next = div_ge ? div_diff : div_shift[WIDTH-1:0];
            opa_next = {opa_reg[WIDTH-2:0], div_ge};
            opb_next = opb_reg;
        end
        if (op_reg == OP_DIV) begin
            iter_result = opa_reg;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            op_reg     <= '0;
            opa_reg    <= '0;
            opb_reg    <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            result_reg <= '0;
            zero_reg   <= 1'b0;
            carry_reg  <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done_reg <= 1'b0;
                    busy_reg <= 1'b0;
                    // busy_reg is still high on the done cycle, so a start there is ignored.
                    if (start && !busy_reg) begin
                        op_reg    <= opcode;
                        opa_reg   <= a;
                        opb_reg   <= b;
                        acc_reg   <= '0;
                        cnt_reg   <= CW'(WIDTH);
                        busy_reg  <= 1'b1;
                        state_reg <= start_iter ? S_ITER : S_EXEC;
                    end
                end
                S_EXEC: begin
                    result_reg <= exec_result_next;
                    zero_reg   <= (exec_result_next == '0);
                    carry_reg  <= exec_carry_next;
                    err_reg    <= exec_err_next;
                    done_reg   <= 1'b1;
                    state_reg  <= S_IDLE;
                end
                S_ITER: begin
                    acc_reg <= acc_next;
                    opa_reg <= opa_next;
                    opb_reg <= opb_next;
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == CW'(1)) begin
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    result_reg <= iter_result;
                    zero_reg   <= (iter_result == '0);
                    carry_reg  <= 1'b0;
                    err_reg    <= 1'b0;
                    done_reg   <= 1'b1;
                    state_reg  <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_exec_unit.sv
// Directed bench for cpu_exec_unit (WIDTH=32): latency, results, flags, handshake and reset abort.
module tb_cpu_exec_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;
    logic        carry;
    logic        err;

    int checks = 0;
    int errors = 0;

    cpu_exec_unit #(.WIDTH(32), .OPW(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .opcode (opcode),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero),
        .carry  (carry),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op; returns with the bench sitting in the done cycle (lat=-1 on timeout).
    task automatic run_op(input logic [7:0] op, input logic [31:0] av, input logic [31:0] bv,
                          output int lat);
        opcode = op;
        a      = av;
        b      = bv;
        start  = 1'b1;
        tick();
        start = 1'b0;
        lat   = -1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (done) begin
                lat = c;
                break;
            end
        end
        $display("op=0x%0h a=0x%0h b=0x%0h lat=%0d result=0x%0h z=%0b c=%0b e=%0b",
                 op, av, bv, lat, result, zero, carry, err);
    endtask

    // Flags packed as {zero, carry, err}.
    task automatic chk_op(input string tag, input int lat, input int exp_lat,
                          input logic [31:0] exp_res, input logic [2:0] exp_flags);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " result"}, result, exp_res);
        chk({tag, " flags"}, 32'({zero, carry, err}), 32'(exp_flags));
    endtask

    initial begin
        int lat;
        int busy_gap;
        int done_cnt;

        rst    = 1'b1;
        start  = 1'b0;
        opcode = '0;
        a      = '0;
        b      = '0;
        tick();
        tick();
        chk("reset busy/done", 32'({busy, done}), 32'h0);
        chk("reset result", result, 32'h0);
        chk("reset flags", 32'({zero, carry, err}), 32'h0);
        rst = 1'b0;
        tick();

        // ADD wrap-around with carry out
        run_op(8'h00, 32'hFFFF_FFFF, 32'h1, lat);
        chk_op("ADD wrap", lat, 1, 32'h0, 3'b110);
        chk("ADD busy in done cycle", 32'(busy), 32'h1);
        tick();
        chk("ADD done pulse ends", 32'({busy, done}), 32'h0);
        tick();

        // SUB borrow, then a start held through the done cycle
        run_op(8'h01, 32'd5, 32'd7, lat);
        chk_op("SUB borrow", lat, 1, 32'hFFFF_FFFE, 3'b010);
        opcode = 8'h04;
        a      = 32'h1234;
        b      = 32'h1234;
        start  = 1'b1;
        tick();
        chk("start on done cycle ignored", 32'({busy, done}), 32'h0);
        tick();
        start = 1'b0;
        chk("start accepted when idle", 32'(busy), 32'h1);
        tick();
        chk("XOR done", 32'(done), 32'h1);
        chk("XOR result", result, 32'h0);
        chk("XOR flags", 32'({zero, carry, err}), 32'h4);
        $display("op=0x4 a=0x1234 b=0x1234 result=0x%0h z=%0b", result, zero);
        tick();

        // MUL with a stray start mid-iteration
        opcode   = 8'h07;
        a        = 32'd12345;
        b        = 32'd678;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        lat      = -1;
        busy_gap = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 10) begin
                opcode = 8'h00;
                a      = 32'd1;
                b      = 32'd1;
                start  = 1'b1;
            end
            tick();
            start = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
            if (!busy) busy_gap++;
        end
        $display("op=0x7 a=12345 b=678 lat=%0d result=%0d", lat, result);
        chk_op("MUL", lat, 33, 32'd8369910, 3'b000);
        chk("MUL busy throughout", 32'(busy_gap), 32'h0);
        tick();
        tick();
        chk("MUL result held", result, 32'd8369910);

        // Remaining single-cycle ops, including shift-amount truncation
        run_op(8'h02, 32'h0000_F0F0, 32'h0000_0FF0, lat);
        chk_op("AND", lat, 1, 32'h0000_00F0, 3'b000);
        tick();
        run_op(8'h03, 32'h0000_F0F0, 32'h0000_0FF0, lat);
        chk_op("OR", lat, 1, 32'h0000_FFF0, 3'b000);
        tick();
        run_op(8'h05, 32'h1, 32'd33, lat);
        chk_op("SHL mod width", lat, 1, 32'h2, 3'b000);
        tick();
        run_op(8'h06, 32'h8000_0000, 32'd31, lat);
        chk_op("SHR", lat, 1, 32'h1, 3'b000);
        tick();

`ifdef EXEC_DIV_EN
        run_op(8'h08, 32'd100, 32'd7, lat);
        chk_op("DIV", lat, 33, 32'd14, 3'b000);
        tick();
        run_op(8'h09, 32'd100, 32'd7, lat);
        chk_op("MOD", lat, 33, 32'd2, 3'b000);
        tick();
        run_op(8'h08, 32'd9, 32'd0, lat);
        chk_op("DIV by zero", lat, 1, 32'hFFFF_FFFF, 3'b001);
        tick();
        run_op(8'h09, 32'd9, 32'd0, lat);
        chk_op("MOD by zero", lat, 1, 32'd9, 3'b001);
        tick();
`else
        run_op(8'h08, 32'd100, 32'd7, lat);
        chk_op("DIV disabled", lat, 1, 32'h0, 3'b101);
        tick();
        run_op(8'h09, 32'd100, 32'd7, lat);
        chk_op("MOD disabled", lat, 1, 32'h0, 3'b101);
        tick();
`endif

        run_op(8'h3F, 32'd3, 32'd4, lat);
        chk_op("illegal 0x3F", lat, 1, 32'h0, 3'b101);
        tick();

        // Reset mid-MUL aborts with no done pulse
        opcode = 8'h07;
        a      = 32'd12345;
        b      = 32'd678;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy/done", 32'({busy, done}), 32'h0);
        chk("abort result", result, 32'h0);
        chk("abort flags", 32'({zero, carry, err}), 32'h0);
        done_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (done) done_cnt++;
        end
        $display("reset abort: done pulses after rst=%0d", done_cnt);
        chk("no done after abort", 32'(done_cnt), 32'h0);

        run_op(8'h00, 32'd2, 32'd3, lat);
        chk_op("ADD after abort", lat, 1, 32'd5, 3'b000);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
